// File: rtl/aes_pkg.sv
// Shared AES definitions for the key-schedule sequencer and its g function:
// round-constant parameters, GF(2^8) helpers and the sequencer state type.
package aes_pkg;

   localparam logic [7:0] AES_RCON_INIT = 8'h01;
   localparam logic [7:0] AES_RCON_POLY = 8'h1B;
   localparam int         AES_NUM_RK    = 11;

   typedef enum logic [0:0] {
      KX_IDLE = 1'b0,
      KX_EMIT = 1'b1
   } aes_kx_state_t;

   // Multiply by x in GF(2^8) modulo the AES polynomial.
   function automatic logic [7:0] xtime(input logic [7:0] r);
      return {r[6:0], 1'b0} ^ (r[7] ? AES_RCON_POLY : 8'h00);
   endfunction

   // General GF(2^8) product, shift-and-add over the bits of b.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] sh;
      acc = 8'h00;
      sh  = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) begin
            acc = acc ^ sh;
         end else begin
            acc = acc;
         end
         sh = xtime(sh);
      end
      return acc;
   endfunction

endpackage

// File: rtl/g_function.sv
// AES key-schedule g function: RotWord, SubWord and round-constant XOR.
// The S-box is computed as the GF(2^8) inverse (a^254, zero maps to zero)
// followed by the AES affine transform, so no lookup table is needed.
module g_function
   import aes_pkg::*;
(
   input  logic [31:0] w_in,
   input  logic [31:0] rcon_in,
   output logic [31:0] g_out
);

   // S-box for one byte: inverse by square-and-multiply, then affine map.
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] p;
      logic [7:0] inv;
      p   = a;
      inv = 8'h01;
      for (int i = 1; i < 8; i++) begin
         p   = gf_mul(p, p);
         inv = gf_mul(inv, p);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   logic [31:0] rot_s;

   // Rotate left by one byte, substitute each byte, then add the round constant.
   always_comb begin
      rot_s = {w_in[23:0], w_in[31:24]};
      g_out = {sbox(rot_s[31:24]), sbox(rot_s[23:16]),
               sbox(rot_s[15:8]),  sbox(rot_s[7:0])} ^ rcon_in;
   end

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key-schedule sequencer. Loads a cipher key and streams
// round keys rk0..rk10 over a valid/ready handshake, one per cycle when the
// consumer is ready. Optional round-key store enabled by the macro
// AES_KEY_EXPAND_CACHE_EN (adds rd_idx / rd_data / cache_valid).
module aes_key_expand
   import aes_pkg::*;
#(
   parameter int NUM_ROUNDS = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         key_valid,
   output logic         key_ready,
   input  logic [127:0] key_in,
   output logic         rk_valid,
   input  logic         rk_ready,
   output logic [127:0] rk_data,
   output logic [3:0]   rk_idx,
   output logic         rk_last,
   output logic         busy
`ifdef AES_KEY_EXPAND_CACHE_EN
   ,
   input  logic [3:0]   rd_idx,
   output logic [127:0] rd_data,
   output logic         cache_valid
`endif
);

   localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

   aes_kx_state_t state_q, state_d;
   logic [127:0]  w_q, w_d;
   logic [3:0]    idx_q, idx_d;
   logic [7:0]    rcon_q, rcon_d;
   logic          rk_valid_q, rk_valid_d;
   logic          rk_last_q, rk_last_d;
   logic          busy_q, busy_d;
   logic          key_ready_q, key_ready_d;

   logic          rk_hs_s;
   logic          key_acc_s;
   logic [31:0]   g_out_s;
   logic [127:0]  next_w_s;

   g_function u_g (
      .w_in    (w_q[31:0]),
      .rcon_in ({rcon_q, 24'h000000}),
      .g_out   (g_out_s)
   );

   // Next round key: each word chains off the freshly updated word before it.
   always_comb begin
      next_w_s[127:96] = w_q[127:96] ^ g_out_s;
      next_w_s[95:64]  = w_q[95:64]  ^ next_w_s[127:96];
      next_w_s[63:32]  = w_q[63:32]  ^ next_w_s[95:64];
      next_w_s[31:0]   = w_q[31:0]   ^ next_w_s[63:32];
   end

   // Sequencer: load a key in IDLE, advance one round per accepted round key.
   always_comb begin
      state_d   = state_q;
      w_d       = w_q;
      idx_d     = idx_q;
      rcon_d    = rcon_q;
      key_acc_s = 1'b0;
      rk_hs_s   = 1'b0;
      case (state_q)
         KX_IDLE: begin
            if (key_valid) begin
               key_acc_s = 1'b1;
               w_d       = key_in;
               idx_d     = 4'd0;
               rcon_d    = AES_RCON_INIT;
               state_d   = KX_EMIT;
            end else begin
               state_d   = KX_IDLE;
            end
         end
         KX_EMIT: begin
            if (rk_ready) begin
               rk_hs_s = 1'b1;
               if (idx_q == LAST_IDX) begin
                  // Final key stays on rk_data; only the state moves.
                  state_d = KX_IDLE;
               end else begin
                  w_d    = next_w_s;
                  idx_d  = idx_q + 4'd1;
                  rcon_d = xtime(rcon_q);
               end
            end else begin
               state_d = KX_EMIT;
            end
         end
         default: begin
            state_d = KX_IDLE;
         end
      endcase
   end

   // Output flags are precomputed from the next state so they leave flops.
   always_comb begin
      rk_valid_d  = (state_d == KX_EMIT);
      busy_d      = (state_d == KX_EMIT);
      key_ready_d = (state_d == KX_IDLE);
      rk_last_d   = (state_d == KX_EMIT) && (idx_d == LAST_IDX);
   end

   // State and datapath registers; reset abandons any partial schedule.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= KX_IDLE;
         w_q         <= 128'd0;
         idx_q       <= 4'd0;
         rcon_q      <= AES_RCON_INIT;
         rk_valid_q  <= 1'b0;
         rk_last_q   <= 1'b0;
         busy_q      <= 1'b0;
         key_ready_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         w_q         <= w_d;
         idx_q       <= idx_d;
         rcon_q      <= rcon_d;
         rk_valid_q  <= rk_valid_d;
         rk_last_q   <= rk_last_d;
         busy_q      <= busy_d;
         key_ready_q <= key_ready_d;
      end
   end

   assign key_ready = key_ready_q;
   assign rk_valid  = rk_valid_q;
   assign rk_data   = w_q;
   assign rk_idx    = idx_q;
   assign rk_last   = rk_last_q;
   assign busy      = busy_q;

`ifdef AES_KEY_EXPAND_CACHE_EN
   logic [127:0] store_q [AES_NUM_RK];
   logic [127:0] store_d [AES_NUM_RK];
   logic [127:0] rd_data_q, rd_data_d;
   logic         cache_valid_q, cache_valid_d;

   // Capture every emitted round key; readback is a registered lookup.
   always_comb begin
      store_d = store_q;
      if (rk_hs_s) begin
         store_d[idx_q] = w_q;
      end else begin
         store_d = store_q;
      end
      if (rd_idx < 4'(AES_NUM_RK)) begin
         rd_data_d = store_q[rd_idx];
      end else begin
         rd_data_d = 128'd0;
      end
      if (key_acc_s) begin
         cache_valid_d = 1'b0;
      end else if (rk_hs_s && (idx_q == LAST_IDX)) begin
         cache_valid_d = 1'b1;
      end else begin
         cache_valid_d = cache_valid_q;
      end
   end

   // Round-key store, read register and completeness flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < AES_NUM_RK; i++) begin
            store_q[i] <= 128'd0;
         end
         rd_data_q     <= 128'd0;
         cache_valid_q <= 1'b0;
      end else begin
         store_q       <= store_d;
         rd_data_q     <= rd_data_d;
         cache_valid_q <= cache_valid_d;
      end
   end

   assign rd_data     = rd_data_q;
   assign cache_valid = cache_valid_q;
`endif

endmodule

// File: tb/tb_aes_key_expand.sv
// Scoreboard bench for aes_key_expand: a FIPS-197 style key-expansion model
// (table S-box built by brute-force inversion) predicts every round key.
module tb_aes_key_expand;

   typedef struct {
      logic [127:0] data;
      logic [3:0]   idx;
      int           off;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         key_valid;
   logic         key_ready;
   logic [127:0] key_in;
   logic         rk_valid;
   logic         rk_ready;
   logic [127:0] rk_data;
   logic [3:0]   rk_idx;
   logic         rk_last;
   logic         busy;
`ifdef AES_KEY_EXPAND_CACHE_EN
   logic [3:0]   rd_idx;
   logic [127:0] rd_data;
   logic         cache_valid;
`endif

   int           n_cmp = 0;
   int           n_err = 0;
   int           cyc = 0;
   int           acc_edge = 0;
   bit           ready_mode = 1'b1;
   exp_t         sb[$];
   logic [7:0]   sbox_t [256];
   logic [7:0]   rcon_t [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
   logic [127:0] model_rk [11];
   logic [127:0] dut_rk [16];
   bit           stall_prev = 1'b0;
   logic [127:0] prev_data;
   logic [3:0]   prev_idx;
   logic         prev_last;

   aes_key_expand dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_valid (key_valid),
      .key_ready (key_ready),
      .key_in    (key_in),
      .rk_valid  (rk_valid),
      .rk_ready  (rk_ready),
      .rk_data   (rk_data),
      .rk_idx    (rk_idx),
      .rk_last   (rk_last),
      .busy      (busy)
`ifdef AES_KEY_EXPAND_CACHE_EN
      ,
      .rd_idx      (rd_idx),
      .rd_data     (rd_data),
      .cache_valid (cache_valid)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   task automatic build_sbox();
      logic [7:0] inv;
      logic [7:0] s;
      logic [7:0] c;
      c = 8'h63;
      for (int a = 0; a < 256; a++) begin
         inv = 8'h00;
         for (int b = 1; b < 256; b++) begin
            if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
         end
         for (int i = 0; i < 8; i++) begin
            s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8]
                 ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ c[i];
         end
         sbox_t[a] = s;
      end
   endtask

   // Standard word-array key expansion, 44 words.
   task automatic build_model(input logic [127:0] k);
      logic [31:0] w [44];
      logic [31:0] t;
      for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i - 1];
         if (i % 4 == 0) begin
            t = {sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]], sbox_t[t[31:24]]}
                ^ {rcon_t[i / 4 - 1], 24'h000000};
         end
         w[i] = w[i - 4] ^ t;
      end
      for (int r = 0; r < 11; r++) begin
         model_rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
      end
   endtask

   task automatic push_model(input logic [127:0] k, input bit timed);
      exp_t e;
      build_model(k);
      for (int r = 0; r < 11; r++) begin
         e.data = model_rk[r];
         e.idx  = 4'(r);
         e.off  = timed ? r : -1;
         sb.push_back(e);
      end
      for (int i = 0; i < 16; i++) dut_rk[i] = 128'd0;
   endtask

   task automatic send_key(input logic [127:0] k);
      int b;
      b = 0;
      @(negedge clk);
      while (!key_ready && b < 100) begin
         @(negedge clk);
         b++;
      end
      if (!key_ready) begin
         n_cmp++;
         n_err++;
         $display("FAIL key_ready_timeout: got 0 expected 1");
      end
      key_in    = k;
      key_valid = 1'b1;
      @(posedge clk);
      #1;
      acc_edge  = cyc;
      key_valid = 1'b0;
   endtask

   task automatic drain();
      int b;
      b = 0;
      while (sb.size() != 0 && b < 400) begin
         @(negedge clk);
         #1;
         b++;
      end
      chk("drain_left", 128'(sb.size()), 128'd0);
   endtask

   task automatic check_idle_at_12();
      @(negedge clk);
      chk("idle_cycle", 128'(cyc - acc_edge), 128'd11);
      chk("idle_key_ready", 128'(key_ready), 128'd1);
      chk("idle_busy", 128'(busy), 128'd0);
      chk("idle_rk_valid", 128'(rk_valid), 128'd0);
   endtask

   // Consumer: rk_ready changes just after each rising edge.
   initial begin
      rk_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         rk_ready = ready_mode ? 1'b1 : 1'($urandom_range(0, 1));
      end
   end

   // Monitor: compare every handshake against the scoreboard; check stalls.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && rk_valid) begin
         if (stall_prev) begin
            chk("stall_data", rk_data, prev_data);
            chk("stall_idx_last", {prev_idx, prev_last}, {rk_idx, rk_last});
         end
         if (rk_ready) begin
            stall_prev = 1'b0;
            if (sb.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_rk: got idx %0d expected none", rk_idx);
            end else begin
               e = sb.pop_front();
               chk("rk_data", rk_data, e.data);
               chk("rk_idx", 128'(rk_idx), 128'(e.idx));
               chk("rk_last", 128'(rk_last), 128'(e.idx == 4'd10));
               if (e.off >= 0) chk("rk_cycle", 128'(cyc - acc_edge), 128'(e.off));
            end
            dut_rk[rk_idx] = rk_data;
         end else begin
            stall_prev = 1'b1;
            prev_data  = rk_data;
            prev_idx   = rk_idx;
            prev_last  = rk_last;
         end
      end else begin
         stall_prev = 1'b0;
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] ka;
      logic [127:0] kb;
      int b;
      bit bad;
      rst_n     = 1'b0;
      key_valid = 1'b0;
      key_in    = 128'd0;
`ifdef AES_KEY_EXPAND_CACHE_EN
      rd_idx    = 4'd0;
`endif
      build_sbox();
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_rk_valid", 128'(rk_valid), 128'd0);
      chk("rst_busy", 128'(busy), 128'd0);
      chk("rst_key_ready", 128'(key_ready), 128'd1);
      chk("rst_rk_last", 128'(rk_last), 128'd0);
      chk("rst_rk_data", rk_data, 128'd0);
      chk("rst_rk_idx", 128'(rk_idx), 128'd0);

      // FIPS-197 key, consumer always ready
      ready_mode = 1'b1;
      push_model(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b1);
      send_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
      drain();
      check_idle_at_12();
      chk("fips_rk1", dut_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
      chk("fips_rk10", dut_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
`ifdef AES_KEY_EXPAND_CACHE_EN
      chk("cache_valid_set", 128'(cache_valid), 128'd1);
      for (int i = 0; i < 11; i++) begin
         rd_idx = 4'(i);
         @(posedge clk);
         #1;
         chk("cache_rd", rd_data, model_rk[i]);
      end
      rd_idx = 4'd15;
      @(posedge clk);
      #1;
      chk("cache_rd_oob", rd_data, 128'd0);
`endif

      // All-zero key
      push_model(128'd0, 1'b1);
      send_key(128'd0);
`ifdef AES_KEY_EXPAND_CACHE_EN
      chk("cache_valid_clr", 128'(cache_valid), 128'd0);
`endif
      drain();
      check_idle_at_12();
      chk("zero_rk1", dut_rk[1], 128'h62636363626363636263636362636363);
      chk("zero_rk10", dut_rk[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

      // Random keys under random backpressure
      ready_mode = 1'b0;
      for (int n = 0; n < 4; n++) begin
         ka = {$urandom, $urandom, $urandom, $urandom};
         push_model(ka, 1'b0);
         send_key(ka);
         drain();
         for (int r = 0; r < 11; r++) chk("bp_rk_seen", dut_rk[r], model_rk[r]);
      end

      // key_valid held through EMIT with a different key
      ready_mode = 1'b1;
      ka = {$urandom, $urandom, $urandom, $urandom};
      kb = ~ka;
      push_model(ka, 1'b1);
      build_model(kb);
      for (int r = 0; r < 11; r++) sb.push_back('{model_rk[r], 4'(r), r});
      @(negedge clk);
      while (!key_ready) @(negedge clk);
      key_in    = ka;
      key_valid = 1'b1;
      @(posedge clk);
      #1;
      acc_edge = cyc;
      key_in   = kb;
      bad = 1'b0;
      b   = 0;
      @(negedge clk);
      while (!key_ready && b < 40) begin
         if (!busy) bad = 1'b1;
         @(negedge clk);
         b++;
      end
      chk("hold_key_ready_low", 128'(bad), 128'd0);
      chk("second_accept_cycle", 128'(cyc - acc_edge), 128'd11);
      @(posedge clk);
      #1;
      acc_edge  = cyc;
      key_valid = 1'b0;
      drain();

      // Reset mid-expansion at idx 5
      ka = {$urandom, $urandom, $urandom, $urandom};
      push_model(ka, 1'b1);
      send_key(ka);
      b = 0;
      while (!(rk_valid && rk_idx == 4'd5) && b < 40) begin
         @(negedge clk);
         #1;
         b++;
      end
      chk("mid_idx_reached", 128'(rk_idx), 128'd5);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_rk_valid", 128'(rk_valid), 128'd0);
      chk("mid_rst_busy", 128'(busy), 128'd0);
      chk("mid_rst_key_ready", 128'(key_ready), 128'd1);
      chk("mid_rst_rk_data", rk_data, 128'd0);
      sb.delete();
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      kb = {$urandom, $urandom, $urandom, $urandom};
      push_model(kb, 1'b1);
      send_key(kb);
      drain();
      check_idle_at_12();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
